// File: rtl/vx_raster_slice_sched_pkg.sv
// Shared raster types: tile payload and scheduler state encoding.
package VX_raster_pkg;

  localparam int unsigned RASTER_DIM_BITS  = 16;
  localparam int unsigned RASTER_PID_BITS  = 16;
  localparam int unsigned RASTER_DATA_BITS = 32;

  typedef struct packed {
    logic [RASTER_DIM_BITS-1:0]             xloc;
    logic [RASTER_DIM_BITS-1:0]             yloc;
    logic [RASTER_PID_BITS-1:0]             pid;
    logic [2:0][2:0][RASTER_DATA_BITS-1:0]  edges;
    logic [2:0][RASTER_DATA_BITS-1:0]       extents;
  } raster_tile_t;

  typedef enum logic [1:0] {
    RASTER_SCHED_RUN   = 2'd0,
    RASTER_SCHED_DRAIN = 2'd1,
    RASTER_SCHED_DONE  = 2'd2
  } raster_sched_state_e;

endpackage

// File: rtl/vx_raster_slice_sched_if.sv
// Tile source / slice-array handshake bundle for the raster slice scheduler.
interface vx_raster_slice_sched_if #(
  parameter int unsigned NUM_SLICES = 4
);
  import VX_raster_pkg::*;

  logic                                valid_in;
  raster_tile_t                        tile_in;
  logic                                ready_in;
  logic                                done_valid_in;
  logic                                done_ready_in;
  logic [NUM_SLICES-1:0]               slice_valid_out;
  raster_tile_t [NUM_SLICES-1:0]       slice_tile_out;
  logic [NUM_SLICES-1:0]               slice_ready_in;
  logic [NUM_SLICES-1:0]               slice_busy_in;

  modport master (
    output valid_in, tile_in, done_valid_in, slice_ready_in, slice_busy_in,
    input  ready_in, done_ready_in, slice_valid_out, slice_tile_out
  );

  modport slave (
    input  valid_in, tile_in, done_valid_in, slice_ready_in, slice_busy_in,
    output ready_in, done_ready_in, slice_valid_out, slice_tile_out
  );

endinterface

// File: rtl/vx_raster_slice_sched_rr_pick.sv
// Circular first-one finder: first available slice at or after rr_ptr.
module VX_raster_rr_pick #(
  parameter int unsigned NUM_SLICES = 4,
  parameter int unsigned SLICE_BITS = 2
) (
  input  logic [NUM_SLICES-1:0] avail,
  input  logic [SLICE_BITS-1:0] rr_ptr,
  output logic [SLICE_BITS-1:0] g,
  output logic                  any
);

  // Walk the slices starting at rr_ptr; the first available one wins.
  always_comb begin
    int unsigned idx;
    logic [SLICE_BITS-1:0] idx_s;
    g     = '0;
    any   = 1'b0;
    idx   = '0;
    idx_s = '0;
    for (int unsigned i = 0; i < NUM_SLICES; i++) begin
      idx   = (32'(rr_ptr) + i) % NUM_SLICES;
      idx_s = SLICE_BITS'(idx);
      if (!any && avail[idx_s]) begin
        g   = idx_s;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vx_raster_slice_sched.sv
// Round-robin tile dispatcher with per-slice holding registers and
// end-of-batch tracking (RUN -> DRAIN -> DONE).
module vx_raster_slice_sched
  import VX_raster_pkg::*;
#(
  parameter int unsigned NUM_SLICES = 4,
  parameter int unsigned SLICE_BITS = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  vx_raster_slice_sched_if.slave   bus,
  output logic                     done_out,
  output logic                     busy_out,
  output logic [31:0]              tiles_dispatched
);

  raster_sched_state_e   state, state_n;
  logic [NUM_SLICES-1:0] hv;
  logic [NUM_SLICES-1:0] avail;
  logic [SLICE_BITS-1:0] rr_ptr;
  logic [SLICE_BITS-1:0] g;
  logic                  any;
  logic                  accept;
  logic                  idle;
  logic                  idle_q;

  // A slice can take a tile when empty or when it drains this cycle.
  assign avail  = ~hv | bus.slice_ready_in;
  assign idle   = !(|hv) && !(|bus.slice_busy_in);
  assign accept = (state == RASTER_SCHED_RUN) && bus.valid_in && any;

  VX_raster_rr_pick #(
    .NUM_SLICES (NUM_SLICES),
    .SLICE_BITS (SLICE_BITS)
  ) u_rr_pick (
    .avail  (avail),
    .rr_ptr (rr_ptr),
    .g      (g),
    .any    (any)
  );

  // Next-state and handshake outputs.
  always_comb begin
    state_n           = state;
    bus.ready_in      = 1'b0;
    bus.done_ready_in = 1'b0;
    done_out          = 1'b0;
    unique case (state)
      RASTER_SCHED_RUN: begin
        bus.ready_in      = any;
        bus.done_ready_in = !bus.valid_in;
        if (!bus.valid_in && bus.done_valid_in) state_n = RASTER_SCHED_DRAIN;
      end
      RASTER_SCHED_DRAIN: begin
        if (idle && idle_q) state_n = RASTER_SCHED_DONE;
      end
      RASTER_SCHED_DONE: begin
        done_out = 1'b1;
        state_n  = RASTER_SCHED_RUN;
      end
      default: state_n = RASTER_SCHED_RUN;
    endcase
  end

  assign busy_out = (state != RASTER_SCHED_RUN) || (|hv) || (|bus.slice_busy_in);

  // State, idle history, round-robin pointer and dispatch counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= RASTER_SCHED_RUN;
      idle_q           <= 1'b0;
      rr_ptr           <= '0;
      tiles_dispatched <= '0;
    end else begin
      state  <= state_n;
      // idle must be seen on two consecutive DRAIN cycles; slice busy lags its handshake by one
      idle_q <= (state == RASTER_SCHED_DRAIN) ? idle : 1'b0;
      if (accept) begin
        rr_ptr           <= (32'(g) == NUM_SLICES - 1) ? '0 : g + 1'b1;
        tiles_dispatched <= tiles_dispatched + 32'd1;
      end
    end
  end

  for (genvar k = 0; k < NUM_SLICES; k++) begin : g_slice
    logic         hv_r;
    raster_tile_t hd_r;

    // Holding register: load on grant, clear on slice handshake.
    always_ff @(posedge clk) begin
      if (reset) begin
        hv_r <= 1'b0;
      end else if (accept && (g == SLICE_BITS'(k))) begin
        hv_r <= 1'b1;
        hd_r <= bus.tile_in;
      end else if (bus.slice_ready_in[k]) begin
        hv_r <= 1'b0;
      end
    end

    assign hv[k]                 = hv_r;
    assign bus.slice_tile_out[k] = hd_r;
  end

  assign bus.slice_valid_out = hv;

endmodule
